// File: rtl/comparator_pkg.sv
// comparator_pkg: default widths and write-port record shared by the lockstep comparator
package comparator_pkg;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_CNT_W  = 8;
  typedef struct packed {
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wport_t;
endpackage

// File: rtl/wport_mismatch.sv
// wport_mismatch: combinational divergence detector for two register-file write ports
module wport_mismatch #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              w_en1,
  input  logic              w_en2,
  input  logic [ADDR_W-1:0] w_addr1,
  input  logic [ADDR_W-1:0] w_addr2,
  input  logic [DATA_W-1:0] w_data1,
  input  logic [DATA_W-1:0] w_data2,
  output logic              mismatch
);
  // address/data only matter when both cores actually write
  assign mismatch = (w_en1 != w_en2) | (w_en1 & w_en2 & ((w_addr1 != w_addr2) | (w_data1 != w_data2)));
endmodule

// File: rtl/lockstep_comparator.sv
// lockstep_comparator: registers core-1 writes and flags/counts core divergence
module lockstep_comparator
  import comparator_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w_en1,
  input  logic              w_en2,
  input  logic [ADDR_W-1:0] w_addr1,
  input  logic [ADDR_W-1:0] w_addr2,
  input  logic [DATA_W-1:0] w_data1,
  input  logic [DATA_W-1:0] w_data2,
  input  logic              err_clr,
  output logic              error,
  output logic [DATA_W-1:0] data,
  output logic              w_en,
  output logic [ADDR_W-1:0] w_addr,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  err_count
);
  logic              mismatch;
  logic              error_q, w_en_q, sticky_q, sticky_d;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] w_addr_q;
  logic [CNT_W-1:0]  count_q, count_d;

  wport_mismatch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cmp (
    .w_en1   (w_en1),
    .w_en2   (w_en2),
    .w_addr1 (w_addr1),
    .w_addr2 (w_addr2),
    .w_data1 (w_data1),
    .w_data2 (w_data2),
    .mismatch(mismatch)
  );

  // a mismatch coinciding with err_clr still counts, and the counter never wraps
  always_comb begin
    sticky_d = mismatch | (sticky_q & ~err_clr);
    count_d  = err_clr ? CNT_W'(mismatch) : (mismatch & ~&count_q) ? count_q + CNT_W'(1) : count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      error_q  <= 1'b0;
      data_q   <= '0;
      w_en_q   <= 1'b0;
      w_addr_q <= '0;
      sticky_q <= 1'b0;
      count_q  <= '0;
    end else begin
      error_q  <= mismatch;
      data_q   <= w_data1;
      w_en_q   <= w_en1 & ~mismatch;
      w_addr_q <= w_addr1;
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  assign error      = error_q;
  assign data       = data_q;
  assign w_en       = w_en_q;
  assign w_addr     = w_addr_q;
  assign err_sticky = sticky_q;
  assign err_count  = count_q;
endmodule

// File: tb/tb_lockstep_comparator.sv
// tb_lockstep_comparator: directed and random checks against a behavioural lockstep model
module tb_lockstep_comparator;
  import comparator_pkg::*;
  logic        clk = 1'b0, reset = 1'b0, w_en1 = 1'b0, w_en2 = 1'b0, err_clr = 1'b0;
  logic [4:0]  w_addr1 = '0, w_addr2 = '0, w_addr;
  logic [31:0] w_data1 = '0, w_data2 = '0, data;
  logic        error, w_en, err_sticky;
  logic [7:0]  err_count;
  int checks = 0, errors = 0;
  int m_cnt = 0;
  logic m_err = 0, m_wen = 0, m_sticky = 0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;

  lockstep_comparator dut (
    .clk(clk), .reset(reset), .w_en1(w_en1), .w_en2(w_en2),
    .w_addr1(w_addr1), .w_addr2(w_addr2), .w_data1(w_data1), .w_data2(w_data2),
    .err_clr(err_clr), .error(error), .data(data), .w_en(w_en), .w_addr(w_addr),
    .err_sticky(err_sticky), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one cycle: drive two core write ports, advance the model, compare every output
  task automatic step(input wport_t c1, input wport_t c2, input logic clr, input logic rst);
    bit diverge;
    w_en1 = c1.we; w_addr1 = c1.addr; w_data1 = c1.data;
    w_en2 = c2.we; w_addr2 = c2.addr; w_data2 = c2.data;
    err_clr = clr; reset = rst;
    @(posedge clk);
    #1;
    diverge = (c1.we || c2.we) && (c1 != c2);
    if (rst) begin
      m_err = 0; m_data = '0; m_wen = 0; m_addr = '0; m_sticky = 0; m_cnt = 0;
    end else begin
      m_err = diverge;
      m_data = c1.data;
      m_addr = c1.addr;
      m_wen = c1.we && !diverge;
      m_sticky = diverge || (m_sticky && !clr);
      m_cnt = clr ? int'(diverge) : (diverge && m_cnt < 255) ? m_cnt + 1 : m_cnt;
    end
    check("error", error, m_err);
    check("data", data, m_data);
    check("w_en", w_en, m_wen);
    check("w_addr", w_addr, m_addr);
    check("err_sticky", err_sticky, m_sticky);
    check("err_count", err_count, m_cnt);
  endtask

  function automatic wport_t wp(input logic we, input int addr, input int dat);
    wport_t p;
    p.we = we; p.addr = addr[4:0]; p.data = dat;
    return p;
  endfunction

  initial begin
    wport_t a, b;
    step(wp(0, 0, 0), wp(0, 0, 0), 0, 1);
    check("reset_count", err_count, 0);
    step(wp(1, 10, 100), wp(1, 10, 100), 0, 0);
    check("t1_error", error, 0); check("t1_data", data, 100); check("t1_wen", w_en, 1); check("t1_addr", w_addr, 10);
    step(wp(1, 10, 100), wp(1, 11, 100), 0, 0);
    check("t2_error", error, 1); check("t2_wen", w_en, 0); check("t2_cnt", err_count, 1); check("t2_sticky", err_sticky, 1);
    step(wp(1, 10, 101), wp(1, 10, 100), 0, 0);
    check("t3_data", data, 101); check("t3_cnt", err_count, 2);
    step(wp(1, 10, 100), wp(0, 10, 100), 0, 0);
    check("t4_error", error, 1);
    step(wp(0, 3, 5), wp(0, 7, 9), 0, 0);
    check("t4_idle_error", error, 0); check("t4_idle_wen", w_en, 0);
    step(wp(1, 4, 4), wp(1, 4, 4), 1, 0);
    check("t5_sticky", err_sticky, 0); check("t5_cnt", err_count, 0);
    step(wp(1, 4, 4), wp(1, 4, 5), 1, 0);
    check("t5_clr_mm_sticky", err_sticky, 1); check("t5_clr_mm_cnt", err_count, 1);
    for (int i = 0; i < 300; i++) step(wp(1, i, i), wp(0, i, i), 0, 0);
    check("t6_saturate", err_count, 255);
    step(wp(1, 1, 1), wp(1, 2, 1), 1, 1);
    check("t6_reset_cnt", err_count, 0); check("t6_reset_err", error, 0);
    for (int i = 0; i < 600; i++) begin
      int kind;
      kind = $urandom_range(0, 7);
      a = wp(1, $urandom, $urandom);
      b = a;
      case (kind)
        4: b.addr = a.addr ^ 5'($urandom_range(1, 31));
        5: b.data = a.data ^ ($urandom | 32'h1);
        6: if ($urandom_range(0, 1) == 1) a.we = 0; else b.we = 0;
        7: begin a.we = 0; b = wp(0, $urandom, $urandom); end
        default: ;
      endcase
      step(a, b, $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
